// File: rtl/blu_branch_cmp_pipe_if.sv
// ---------------------------------------------------------------------------
// blu_branch_cmp_pipe_if
// Request/result handshake bundle for the BLU branch comparator pipe.
//   in_valid/in_ready     request handshake (issue -> comparator)
//   in_rs1/in_rs2         operands A and B
//   in_funct3             RISC-V B-type funct3
//   in_tag                opaque tag carried with the request
//   out_valid/out_ready   result handshake (comparator -> PC redirect)
//   out_taken             branch decision
//   out_eq/lt/ltu         comparison flags
//   out_illegal           funct3 is 010 or 011
//   out_tag               tag of the result
// master: request producer / result consumer.  slave: the comparator.
// ---------------------------------------------------------------------------
interface blu_branch_cmp_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [2:0]       in_funct3;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic             out_eq;
    logic             out_lt;
    logic             out_ltu;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_rs1, in_rs2, in_funct3, in_tag, out_ready,
        input  in_ready, out_valid, out_taken, out_eq, out_lt, out_ltu,
               out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_funct3, in_tag, out_ready,
        output in_ready, out_valid, out_taken, out_eq, out_lt, out_ltu,
               out_illegal, out_tag
    );
endinterface

// File: rtl/blu_branch_cmp_pipe.sv
// ---------------------------------------------------------------------------
// blu_branch_cmp_pipe
// Two-stage pipelined branch comparator. Stage 1 holds the request and
// presents A + ~B + 1 to an external prefix adder; stage 2 registers the
// eq/lt/ltu flags derived from the adder result and the branch decision.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             synchronous kill of both pipeline stages
//   bus (slave)       request and result handshakes, see the interface
//   add_a/add_b/add_ci  adder operands: rs1, ~rs2, carry-in 1
//   add_s/add_co      adder sum and carry-out (combinational return)
// ---------------------------------------------------------------------------
module blu_branch_cmp_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    blu_branch_cmp_pipe_if.slave bus,
    output logic [XLEN-1:0]      add_a,
    output logic [XLEN-1:0]      add_b,
    output logic                 add_ci,
    input  logic [XLEN-1:0]      add_s,
    input  logic                 add_co
);

    // A mixed-sign pair is decided by the sign of rs1 alone; the difference
    // sign is only meaningful when both operands share a sign (no overflow).
    function automatic logic signed_lt(input logic a_msb, input logic b_msb,
                                       input logic diff_msb);
        return (a_msb ^ b_msb) ? a_msb : diff_msb;
    endfunction

    function automatic logic is_illegal(input logic [2:0] f3);
        return (f3[2:1] == 2'b01);
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic eq,
                                          input logic lt, input logic ltu);
        logic t;
        case (f3)
            3'b000:  t = eq;
            3'b001:  t = !eq;
            3'b100:  t = lt;
            3'b101:  t = !lt;
            3'b110:  t = ltu;
            3'b111:  t = !ltu;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    logic             vld_p1;
    logic             vld_p2;
    logic [XLEN-1:0]  rs1_p1;
    logic [XLEN-1:0]  rs2_p1;
    logic [2:0]       funct3_p1;
    logic [TAG_W-1:0] tag_p1;

    logic s2_rdy;
    logic in_acc;
    logic s1_adv;
    logic eq_c;
    logic lt_c;
    logic ltu_c;

    // in_ready depends only on state and flush, never on in_valid.
    assign s2_rdy       = !vld_p2 || bus.out_ready;
    assign bus.in_ready = (!vld_p1 || s2_rdy) && !flush;
    assign in_acc       = bus.in_valid && bus.in_ready;
    assign s1_adv       = vld_p1 && s2_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= in_acc || (vld_p1 && !s2_rdy);
            vld_p2 <= s1_adv || (vld_p2 && !bus.out_ready);
        end
    end

    // ---- stage 1: request capture, drives the external adder ----
    always_ff @(posedge clk) begin
        if (in_acc) begin
            rs1_p1    <= bus.in_rs1;
            rs2_p1    <= bus.in_rs2;
            funct3_p1 <= bus.in_funct3;
            tag_p1    <= bus.in_tag;
        end
    end

    assign add_a  = rs1_p1;
    assign add_b  = ~rs2_p1;
    assign add_ci = 1'b1;

    assign eq_c  = (add_s == '0);
    assign ltu_c = !add_co;
    assign lt_c  = signed_lt(rs1_p1[XLEN-1], rs2_p1[XLEN-1], add_s[XLEN-1]);

    // ---- stage 2: flag and decision registers ----
    // A flush leaves the data registers untouched; only the valid bits clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_taken   <= 1'b0;
            bus.out_eq      <= 1'b0;
            bus.out_lt      <= 1'b0;
            bus.out_ltu     <= 1'b0;
            bus.out_illegal <= 1'b0;
            bus.out_tag     <= '0;
        end else if (s1_adv && !flush) begin
            bus.out_taken   <= branch_taken(funct3_p1, eq_c, lt_c, ltu_c);
            bus.out_eq      <= eq_c;
            bus.out_lt      <= lt_c;
            bus.out_ltu     <= ltu_c;
            bus.out_illegal <= is_illegal(funct3_p1);
            bus.out_tag     <= tag_p1;
        end
    end

    assign bus.out_valid = vld_p2;

endmodule
